// File: rtl/prim_arbiter_wrr.sv
// prim_arbiter_wrr: N:1 weighted round-robin arbiter with burst ownership.
// A requester that wins keeps the grant for up to weight[i] accepted transfers
// (a weight of 0 counts as 1), then the grant rotates to the next requester.
// The decision is held while the sink stalls, so an unaccepted beat is never
// re-arbitrated away from a requester that is still asking.

module prim_arbiter_wrr #(
    parameter int N          = 4,
    parameter int DW         = 32,
    parameter int WW         = 4,
    parameter bit EnDataPort = 1'b1,
    localparam int IdxW      = $clog2(N)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N-1:0]         req_i,
    input  logic [N*WW-1:0]      weight_i,
    input  logic [DW-1:0]        data_i [N],
    output logic [N-1:0]         gnt_o,
    output logic [IdxW-1:0]      idx_o,
    output logic                 valid_o,
    output logic [DW-1:0]        data_o,
    input  logic                 ready_i
);

    // A single requester has nothing to arbitrate and IdxW would collapse to 0.
    if (N < 2) begin : gen_n_check
        $error("prim_arbiter_wrr needs N >= 2");
    end

    // Ownership state: the current burst owner, its remaining beats (including
    // the one being offered) and the last index released, which seeds rotation.
    logic            own_q,     own_d;
    logic [IdxW-1:0] own_idx_q, own_idx_d;
    logic [WW-1:0]   credit_q,  credit_d;
    logic [IdxW-1:0] last_q,    last_d;

    logic            own_hold;
    logic [IdxW-1:0] scan_base;
    logic [IdxW-1:0] scan_idx;
    logic            scan_found;
    logic [IdxW-1:0] winner;
    logic [WW-1:0]   w_raw;
    logic [WW-1:0]   w_eff;
    logic [WW-1:0]   rem;
    logic [WW-1:0]   rem_dec;
    logic            accept;

    // Rotating priority scan: the first active request strictly after the
    // base index, wrapping around; the base itself is checked last.
    always_comb begin
        int unsigned     cand;
        logic [IdxW-1:0] cand_idx;
        scan_base  = own_q ? own_idx_q : last_q;
        scan_idx   = '0;
        scan_found = 1'b0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= N; k++) begin
            cand     = (int'(scan_base) + k) % N;
            cand_idx = IdxW'(cand);
            if (!scan_found && req_i[cand_idx]) begin
                scan_found = 1'b1;
                scan_idx   = cand_idx;
            end
        end
    end

    // Winner selection and the credit count that applies to this beat. A live
    // owner keeps its banked credits; a fresh winner starts from its weight,
    // which is the only moment the weight input is looked at.
    always_comb begin
        own_hold = own_q && req_i[own_idx_q];
        winner   = own_hold ? own_idx_q : scan_idx;
        w_raw    = weight_i[int'(winner)*WW +: WW];
        w_eff    = (w_raw == '0) ? WW'(1) : w_raw;
        rem      = own_hold ? credit_q : w_eff;
        rem_dec  = rem - WW'(1);
        valid_o  = |req_i;
        accept   = valid_o && ready_i;
    end

    // Combinational outputs: zero-latency grant, index and valid. The index
    // reads 0 when nobody is requesting so idle cycles look clean downstream.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        if (valid_o) begin
            idx_o = winner;
        end
        if (accept) begin
            gnt_o[winner] = 1'b1;
        end
    end

    // Data path: mux the winner's payload, or tie high when the port is unused.
    if (EnDataPort) begin : gen_data
        always_comb begin
            data_o = '0;
            if (valid_o) begin
                data_o = data_i[winner];
            end
        end
    end else begin : gen_no_data
        logic unused_data;
        always_comb begin
            unused_data = 1'b0;
            for (int i = 0; i < N; i++) begin
                unused_data = unused_data ^ (^data_i[i]);
            end
            data_o = '1;
        end
    end

    // Next ownership state. An accepted beat spends one credit and releases
    // the burst when it was the last one; a stall locks the winner in with its
    // credits untouched; an owner that drops its request with nobody else
    // asking is released without spending anything further.
    always_comb begin
        own_d     = own_q;
        own_idx_d = own_idx_q;
        credit_d  = credit_q;
        last_d    = last_q;
        if (valid_o) begin
            if (ready_i) begin
                if (rem_dec == '0) begin
                    own_d  = 1'b0;
                    last_d = winner;
                end else begin
                    own_d     = 1'b1;
                    own_idx_d = winner;
                    credit_d  = rem_dec;
                end
            end else begin
                own_d     = 1'b1;
                own_idx_d = winner;
                credit_d  = rem;
            end
        end else if (own_q) begin
            own_d  = 1'b0;
            last_d = own_idx_q;
        end
    end

    // State registers; reset drops any burst and makes index 0 the first winner.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            own_q     <= 1'b0;
            own_idx_q <= '0;
            credit_q  <= '0;
            last_q    <= IdxW'(N - 1);
        end else begin
            own_q     <= own_d;
            own_idx_q <= own_idx_d;
            credit_q  <= credit_d;
            last_q    <= last_d;
        end
    end

    // Protocol properties of the grant interface.
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));

    a_gnt_needs_accept : assert property (@(posedge clk_i) disable iff (rst_i)
        (|gnt_o) |-> (ready_i && valid_o));

    a_accept_grants : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && ready_i) |-> (|gnt_o));

    a_gnt_matches_idx : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && ready_i) |-> (gnt_o[idx_o] && req_i[idx_o]));

    a_stall_holds : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (!req_i[$past(idx_o)] || (idx_o == $past(idx_o))));

    a_known_outputs : assert property (@(posedge clk_i) disable iff (rst_i)
        !$isunknown({gnt_o, idx_o, valid_o, data_o}));

    a_credit_nonzero : assert property (@(posedge clk_i) disable iff (rst_i)
        accept |-> (rem != '0));

endmodule

// File: tb/tb_prim_arbiter_wrr.sv
// Testbench for prim_arbiter_wrr: directed burst/stall/drop/reset scenarios
// with fixed expected index sequences, then a long randomized run, all checked
// against a behavioural model of the weighted round-robin rules.

module tb_prim_arbiter_wrr;

    localparam int N    = 4;
    localparam int DW   = 16;
    localparam int WW   = 4;
    localparam int IdxW = 2;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    reqIn;
    logic [N*WW-1:0] weightIn;
    logic [DW-1:0]   dataIn [N];
    logic [N-1:0]    gnt_o;
    logic [IdxW-1:0] idx_o;
    logic            valid_o;
    logic [DW-1:0]   data_o;
    logic            readyIn;

    int checks = 0;
    int errors = 0;

    // Model state: owner is -1 when no burst is open.
    int mOwner;
    int mCredit;
    int mLast;
    int mWin;
    int mRem;
    bit mAny;

    prim_arbiter_wrr #(
        .N(N), .DW(DW), .WW(WW), .EnDataPort(1'b1)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (reqIn),
        .weight_i (weightIn),
        .data_i   (dataIn),
        .gnt_o    (gnt_o),
        .idx_o    (idx_o),
        .valid_o  (valid_o),
        .data_o   (data_o),
        .ready_i  (readyIn)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic int weightOf(int i);
        int w;
        w = int'((weightIn >> (i * WW)) & 16'hF);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic modelReset();
        mOwner  = -1;
        mCredit = 0;
        mLast   = N - 1;
    endtask

    // Decide who the rules say should be served with the present inputs.
    task automatic modelEval();
        int base;
        mAny = (reqIn != '0);
        mWin = 0;
        mRem = 0;
        if (mOwner >= 0 && reqIn[mOwner]) begin
            mWin = mOwner;
            mRem = mCredit;
        end else if (mAny) begin
            base = (mOwner >= 0) ? mOwner : mLast;
            for (int k = 1; k <= N; k++) begin
                if (reqIn[(base + k) % N]) begin
                    mWin = (base + k) % N;
                    break;
                end
            end
            mRem = weightOf(mWin);
        end
    endtask

    // Advance the model across a clock edge using the decision just evaluated.
    task automatic modelStep();
        if (rst_i) begin
            modelReset();
        end else if (mAny) begin
            if (readyIn) begin
                if (mRem - 1 == 0) begin
                    mOwner = -1;
                    mLast  = mWin;
                end else begin
                    mOwner  = mWin;
                    mCredit = mRem - 1;
                end
            end else begin
                mOwner  = mWin;
                mCredit = mRem;
            end
        end else if (mOwner >= 0) begin
            mLast  = mOwner;
            mOwner = -1;
        end
    endtask

    // One cycle: drive inputs after the falling edge, check the combinational
    // outputs against the model, then let the rising edge update both sides.
    // expIdx >= 0 adds a check against a hand-written scenario sequence.
    task automatic applyStimulus(input logic [N-1:0] req, input logic [N*WW-1:0] w,
                                 input logic rdy, input logic rst, input int expIdx);
        logic [N-1:0] expGnt;
        @(negedge clk_i);
        reqIn    = req;
        weightIn = w;
        readyIn  = rdy;
        rst_i    = rst;
        for (int i = 0; i < N; i++) dataIn[i] = DW'($urandom);
        #1;
        modelEval();
        expGnt = '0;
        if (mAny && rdy) expGnt[mWin] = 1'b1;
        checkOutput("valid", 32'(valid_o), 32'(mAny));
        checkOutput("idx", 32'(idx_o), mAny ? mWin : 0);
        checkOutput("gnt", 32'(gnt_o), 32'(expGnt));
        checkOutput("data", 32'(data_o), mAny ? 32'(dataIn[mWin]) : 32'h0);
        if (expIdx >= 0) checkOutput("seqIdx", 32'(idx_o), expIdx);
        @(posedge clk_i);
        modelStep();
    endtask

    task automatic doReset();
        applyStimulus('0, '0, 1'b1, 1'b1, 0);
        applyStimulus('0, '0, 1'b1, 1'b1, 0);
    endtask

    initial begin
        int t1Seq [7] = '{0, 1, 1, 2, 2, 2, 3};
        int t3Idx [7] = '{0, 1, 1, 1, 1, 1, 2};
        bit t3Rdy [7] = '{1, 1, 0, 0, 0, 1, 1};
        int t5Idx [12] = '{0, 1, 1, 2, 2, 2, 3, 0, 1, 1, 1, 1};
        logic [N-1:0]    rReq;
        logic [N*WW-1:0] rW;

        rst_i    = 1'b1;
        reqIn    = '0;
        weightIn = '0;
        readyIn  = 1'b0;
        for (int i = 0; i < N; i++) dataIn[i] = '0;
        repeat (2) @(posedge clk_i);
        modelReset();

        $display("[TB] reset state");
        doReset();
        applyStimulus('0, 16'h1321, 1'b1, 1'b0, 0);

        $display("[TB] T1 weights 1,2,3,1");
        doReset();
        for (int c = 0; c < 21; c++) applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, t1Seq[c % 7]);

        $display("[TB] T2 zero weights");
        doReset();
        for (int c = 0; c < 9; c++) applyStimulus(4'hF, 16'h0000, 1'b1, 1'b0, c % 4);

        $display("[TB] T3 stall holds the decision");
        doReset();
        for (int c = 0; c < 7; c++) applyStimulus(4'hF, 16'h1321, t3Rdy[c], 1'b0, t3Idx[c]);

        $display("[TB] T4 owner drops its request");
        doReset();
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 0);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 1);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 1);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 2);
        applyStimulus(4'hB, 16'h1321, 1'b1, 1'b0, 3);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 0);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 1);

        $display("[TB] T5 weight change mid-burst");
        doReset();
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, t5Idx[0]);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, t5Idx[1]);
        for (int c = 2; c < 12; c++) applyStimulus(4'hF, 16'h1351, 1'b1, 1'b0, t5Idx[c]);
        applyStimulus(4'hF, 16'h1351, 1'b1, 1'b0, 1);
        applyStimulus(4'hF, 16'h1351, 1'b1, 1'b0, 2);

        $display("[TB] T6 reset mid-burst");
        doReset();
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 0);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 1);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b1, 1);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 0);
        applyStimulus(4'hF, 16'h1321, 1'b1, 1'b0, 1);

        $display("[TB] randomized traffic");
        rReq = 4'hF;
        rW   = 16'h1321;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 30) rReq = N'($urandom_range(0, 15));
            if ($urandom_range(0, 99) < 8)  rW   = 16'($urandom);
            applyStimulus(rReq, rW, ($urandom_range(0, 99) < 70), ($urandom_range(0, 199) == 0), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
